// File: rtl/calc2_pkg.sv
// calc2 issuer shared types: command/response codes, tag type, FSM states.
// Imported by calc2_tag_alloc and calc2_port_issuer.
package calc2_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    ERR     = 2'd2,
    TIMEOUT = 2'd3
  } resp_e;

  typedef logic [1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } issue_state_e;

  localparam int NUM_TAGS = 4;

endpackage

// File: rtl/calc2_tag_alloc.sv
// Tag allocator: busy bitmap with lowest-free priority encode.
// Clears and sets land together; the encode always sees the pre-update map.
module calc2_tag_alloc
  import calc2_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       i_set,
  input  logic [3:0] i_clr,
  output logic [3:0] o_busy,
  output tag_t       o_free_tag,
  output logic       o_full
);

  localparam logic [3:0] LP_USE_MASK =
    4'((1 << MAX_OUTSTANDING) - 1);

  logic [3:0] r_busy;
  logic [3:0] w_avail;
  logic [3:0] w_set_mask;
  tag_t       w_free_tag;

  assign w_avail = ~r_busy & LP_USE_MASK;

  // Lowest-numbered free tag wins.
  always_comb begin
    w_free_tag = '0;
    priority case (1'b1)
      w_avail[0]: w_free_tag = 2'd0;
      w_avail[1]: w_free_tag = 2'd1;
      w_avail[2]: w_free_tag = 2'd2;
      w_avail[3]: w_free_tag = 2'd3;
      default:    w_free_tag = 2'd0;
    endcase
  end

  assign w_set_mask = i_set ? (4'b1 << w_free_tag) : 4'b0;

  // Bitmap update: release answered tags, mark the new one busy.
  always_ff @(posedge c_clk) begin
    if (reset) r_busy <= '0;
    else r_busy <= (r_busy & ~i_clr) | w_set_mask;
  end

  assign o_busy     = r_busy;
  assign o_free_tag = w_free_tag;
  assign o_full     = ~|w_avail;

endmodule

// File: rtl/calc2_port_issuer.sv
// Request issuer for one calc2 port: serialises ops into A/B beats.
// Optional per-tag watchdog under CALC2_ISSUE_TIMEOUT_EN.
module calc2_port_issuer
  import calc2_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = 8
`ifdef CALC2_ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_cmd,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [3:0]       req_cmd_out,
  output logic [31:0]      req_data_out,
  output logic [1:0]       req_tag_out,
  input  logic [1:0]       resp_in,
  input  logic [31:0]      resp_data_in,
  input  logic [1:0]       resp_tag_in,
  output logic             done_valid,
  output logic [1:0]       done_resp,
  output logic [31:0]      done_data,
  output logic [1:0]       done_tag,
  output logic [3:0]       busy_tags,
  output logic [CNT_W-1:0] spurious_cnt
);

  issue_state_e r_state;
  logic [31:0]  r_b;

  logic [3:0] w_busy;
  tag_t       w_free_tag;
  logic       w_full;
  logic       w_accept;
  logic       w_resp_hit;
  logic       w_resp_spur;
  logic [3:0] w_resp_clr;
  logic       w_to_fire;
  tag_t       w_to_tag;
  logic [3:0] w_to_clr;

  assign op_ready    = (r_state == IDLE) && !w_full;
  assign w_accept    = op_valid && op_ready;
  assign w_resp_hit  = (resp_in != 2'd0) && w_busy[resp_tag_in];
  assign w_resp_spur = (resp_in != 2'd0) && !w_busy[resp_tag_in];
  assign w_resp_clr  = w_resp_hit ? (4'b1 << resp_tag_in) : 4'b0;

  calc2_tag_alloc #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_alloc (
    .c_clk     (c_clk),
    .reset     (reset),
    .i_set     (w_accept),
    .i_clr     (w_resp_clr | w_to_clr),
    .o_busy    (w_busy),
    .o_free_tag(w_free_tag),
    .o_full    (w_full)
  );

  assign busy_tags = w_busy;

`ifdef CALC2_ISSUE_TIMEOUT_EN
  localparam int LP_WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LP_WD_W-1:0] LP_WD_LIM =
    LP_WD_W'(TIMEOUT_CYCLES - 1);

  logic [LP_WD_W-1:0] r_wd [NUM_TAGS];
  logic [3:0]         w_expired;

  // Expired tags; a same-cycle response for that tag wins.
  always_comb begin
    w_expired = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (w_busy[i] && (r_wd[i] == LP_WD_LIM) &&
          !(w_resp_hit && (resp_tag_in == 2'(i))))
        w_expired[i] = 1'b1;
    end
  end

  // Lowest expired tag fires; a response this cycle defers it.
  always_comb begin
    w_to_tag = '0;
    priority case (1'b1)
      w_expired[0]: w_to_tag = 2'd0;
      w_expired[1]: w_to_tag = 2'd1;
      w_expired[2]: w_to_tag = 2'd2;
      w_expired[3]: w_to_tag = 2'd3;
      default:      w_to_tag = 2'd0;
    endcase
  end

  assign w_to_fire = (|w_expired) && !w_resp_hit;
  assign w_to_clr  = w_to_fire ? (4'b1 << w_to_tag) : 4'b0;

  // Watchdogs: clear on allocation, count (saturating) while busy.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) r_wd[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (w_accept && (w_free_tag == 2'(i)))
          r_wd[i] <= '0;
        else if (w_busy[i] && (r_wd[i] != LP_WD_LIM))
          r_wd[i] <= r_wd[i] + 1'b1;
      end
    end
  end
`else
  assign w_to_fire = 1'b0;
  assign w_to_tag  = '0;
  assign w_to_clr  = '0;
`endif

  // Issue FSM: accept -> A beat (cmd, op_a) -> B beat (op_b).
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_b          <= '0;
      req_cmd_out  <= NOP;
      req_data_out <= '0;
      req_tag_out  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= SEND_A;
            r_b          <= op_b;
            req_cmd_out  <= op_cmd;
            req_data_out <= op_a;
            req_tag_out  <= w_free_tag;
          end else begin
            req_cmd_out  <= NOP;
            req_data_out <= '0;
            req_tag_out  <= '0;
          end
        end
        SEND_A: begin
          r_state      <= SEND_B;
          req_cmd_out  <= NOP;
          req_data_out <= r_b;
        end
        SEND_B: begin
          r_state      <= IDLE;
          req_cmd_out  <= NOP;
          req_data_out <= '0;
          req_tag_out  <= '0;
        end
        default: begin
          r_state      <= IDLE;
          req_cmd_out  <= NOP;
          req_data_out <= '0;
          req_tag_out  <= '0;
        end
      endcase
    end
  end

  // Completion pulse: responses take priority over timeouts.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      done_valid <= 1'b0;
      done_resp  <= NONE;
      done_data  <= '0;
      done_tag   <= '0;
    end else if (w_resp_hit) begin
      done_valid <= 1'b1;
      done_resp  <= (resp_in == 2'd1) ? OK : ERR;
      done_data  <= resp_data_in;
      done_tag   <= resp_tag_in;
    end else if (w_to_fire) begin
      done_valid <= 1'b1;
      done_resp  <= TIMEOUT;
      done_data  <= '0;
      done_tag   <= w_to_tag;
    end else begin
      done_valid <= 1'b0;
      done_resp  <= NONE;
      done_data  <= '0;
      done_tag   <= '0;
    end
  end

  // Saturating count of responses to unallocated tags.
  always_ff @(posedge c_clk) begin
    if (reset) spurious_cnt <= '0;
    else if (w_resp_spur && (spurious_cnt != '1))
      spurious_cnt <= spurious_cnt + 1'b1;
  end

endmodule

// File: tb/tb_calc2_port_issuer.sv
// Directed bench for calc2_port_issuer.
// Timeout section runs only with CALC2_ISSUE_TIMEOUT_EN.
module tb_calc2_port_issuer;
  import calc2_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_a, op_b;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  resp_in;
  logic [31:0] resp_data_in;
  logic [1:0]  resp_tag_in;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [31:0] done_data;
  logic [1:0]  done_tag;
  logic [3:0]  busy_tags;
  logic [7:0]  spurious_cnt;

  int checks = 0;
  int errors = 0;

  always #5 c_clk = ~c_clk;

  calc2_port_issuer dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out),
    .resp_in(resp_in), .resp_data_in(resp_data_in),
    .resp_tag_in(resp_tag_in),
    .done_valid(done_valid), .done_resp(done_resp),
    .done_data(done_data), .done_tag(done_tag),
    .busy_tags(busy_tags), .spurious_cnt(spurious_cnt)
  );

`ifdef CALC2_ISSUE_TIMEOUT_EN
  logic        t_op_ready;
  logic [3:0]  t_req_cmd;
  logic [31:0] t_req_data;
  logic [1:0]  t_req_tag;
  logic        t_done_valid;
  logic [1:0]  t_done_resp;
  logic [31:0] t_done_data;
  logic [1:0]  t_done_tag;
  logic [3:0]  t_busy;
  logic [7:0]  t_spur;

  calc2_port_issuer #(.TIMEOUT_CYCLES(8)) dut_to (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(t_op_ready),
    .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
    .req_cmd_out(t_req_cmd), .req_data_out(t_req_data),
    .req_tag_out(t_req_tag),
    .resp_in(resp_in), .resp_data_in(resp_data_in),
    .resp_tag_in(resp_tag_in),
    .done_valid(t_done_valid), .done_resp(t_done_resp),
    .done_data(t_done_data), .done_tag(t_done_tag),
    .busy_tags(t_busy), .spurious_cnt(t_spur)
  );
`endif

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b);
    op_valid = 1'b1;
    op_cmd = c;
    op_a = a;
    op_b = b;
  endtask

  task automatic set_resp(input logic [1:0] r,
                          input logic [31:0] d,
                          input logic [1:0] t);
    resp_in = r;
    resp_data_in = d;
    resp_tag_in = t;
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0;
    op_cmd = '0;
    op_a = '0;
    op_b = '0;
    set_resp(2'd0, 32'd0, 2'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_cmd", req_cmd_out, 0);
    chk("rst_busy", busy_tags, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_spur", spurious_cnt, 0);
    chk("rst_ready", op_ready, 1);

    // single add
    set_op(ADD, 32'h5, 32'h7);
    chk("add_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("add_a_cmd", req_cmd_out, 1);
    chk("add_a_data", req_data_out, 5);
    chk("add_a_tag", req_tag_out, 0);
    chk("add_a_busy", busy_tags, 1);
    chk("add_a_ready", op_ready, 0);
    tick();
    chk("add_b_cmd", req_cmd_out, 0);
    chk("add_b_data", req_data_out, 7);
    chk("add_b_tag", req_tag_out, 0);
    tick();
    chk("add_idle_data", req_data_out, 0);
    chk("add_idle_ready", op_ready, 1);
    set_resp(2'd1, 32'hC, 2'd0);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    chk("add_dv", done_valid, 1);
    chk("add_dresp", done_resp, 1);
    chk("add_ddata", done_data, 32'hC);
    chk("add_dtag", done_tag, 0);
    chk("add_busy0", busy_tags, 0);
    tick();
    chk("add_pulse", done_valid, 0);

    // fill all four tags
    for (int i = 0; i < 4; i++) begin
      set_op(SUB, 32'h100 + i, 32'h200 + i);
      chk("fill_ready", op_ready, 1);
      tick();
      op_valid = 1'b0;
      chk("fill_tag", req_tag_out, i);
      tick();
      tick();
    end
    chk("fill_busy", busy_tags, 4'hF);
    set_op(SUB, 32'h10, 32'h3);
    chk("full_ready", op_ready, 0);
    set_resp(2'd1, 32'h22, 2'd2);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    chk("free2_dv", done_valid, 1);
    chk("free2_tag", done_tag, 2);
    chk("free2_data", done_data, 32'h22);
    chk("free2_busy", busy_tags, 4'hB);
    chk("free2_noacc", req_cmd_out, 0);
    chk("free2_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("reuse_tag", req_tag_out, 2);
    chk("reuse_cmd", req_cmd_out, 2);
    chk("reuse_a", req_data_out, 32'h10);
    chk("reuse_busy", busy_tags, 4'hF);
    tick();
    chk("reuse_b", req_data_out, 32'h3);
    tick();

    // out-of-order completions
    set_resp(2'd1, 32'h33, 2'd3);
    tick();
    chk("ooo3_tag", done_tag, 3);
    chk("ooo3_data", done_data, 32'h33);
    chk("ooo3_busy", busy_tags, 4'h7);
    set_resp(2'd2, 32'h44, 2'd0);
    tick();
    chk("ooo0_tag", done_tag, 0);
    chk("ooo0_resp", done_resp, 2);
    chk("ooo0_data", done_data, 32'h44);
    chk("ooo0_busy", busy_tags, 4'h6);
    set_resp(2'd3, 32'h55, 2'd1);
    tick();
    chk("r3_resp", done_resp, 2);
    chk("r3_tag", done_tag, 1);
    chk("r3_busy", busy_tags, 4'h4);
    set_resp(2'd1, 32'h0, 2'd2);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    chk("drain_busy", busy_tags, 0);
    chk("no_spur_yet", spurious_cnt, 0);

    // spurious responses and saturation
    set_resp(2'd1, 32'h9, 2'd1);
    tick();
    chk("spur_dv", done_valid, 0);
    chk("spur_cnt1", spurious_cnt, 1);
    repeat (300) tick();
    set_resp(2'd0, 32'd0, 2'd0);
    chk("spur_sat", spurious_cnt, 8'hFF);

    // reset during SEND_A, response during reset discarded
    set_op(ADD, 32'h1, 32'h2);
    tick();
    op_valid = 1'b0;
    chk("rsa_cmd", req_cmd_out, 1);
    reset = 1'b1;
    set_resp(2'd1, 32'h77, 2'd0);
    tick();
    reset = 1'b0;
    set_resp(2'd0, 32'd0, 2'd0);
    chk("rsa_cmd0", req_cmd_out, 0);
    chk("rsa_busy", busy_tags, 0);
    chk("rsa_ready", op_ready, 1);
    chk("rsa_spur", spurious_cnt, 0);
    tick();
    chk("rsa_nodone", done_valid, 0);

`ifdef CALC2_ISSUE_TIMEOUT_EN
    set_op(ADD, 32'h1, 32'h1);
    tick();
    op_valid = 1'b0;
    chk("to_busy", t_busy, 1);
    repeat (6) tick();
    chk("to_early", t_done_valid, 0);
    tick();
    chk("to_early7", t_done_valid, 0);
    tick();
    chk("to_dv", t_done_valid, 1);
    chk("to_resp", t_done_resp, 3);
    chk("to_data", t_done_data, 0);
    chk("to_tag", t_done_tag, 0);
    chk("to_busy0", t_busy, 0);
    set_resp(2'd1, 32'h5, 2'd0);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    chk("to_late_dv", t_done_valid, 0);
    chk("to_late_spur", t_spur, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
